mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 23 ++
 rtl/mem_responder_line_merge.sv | 29 ++
 rtl/mem_responder.sv | 174 +++++++++++++++++
 tb/tb_mem_responder.sv | 398 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// State encoding and line-geometry helpers for mem_responder and its merge sub-module.
// The optional line buffer is selected by MEM_RESPONDER_LINE_BUF_EN inside mem_responder.sv.
package mem_responder_pkg;

    localparam int LINE_WORDS_DEFAULT = 8;

    typedef logic [1:0] mem_responder_state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Byte-offset bits inside one line, i.e. log2(4*LINE_WORDS).
    function automatic int line_offset_bits(input int words);
        return $clog2(words) + 2;
    endfunction

    function automatic int line_index_bits(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/mem_responder_line_merge.sv
// Merges one 32-bit word into a line under a byte enable; combinational, zero latency.
// No handshake: output follows inputs in the same cycle.
module line_merge
    import mem_responder_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT,
    parameter int IDX_W      = line_index_bits(LINE_WORDS)
) (
    input  logic [32*LINE_WORDS-1:0] i_line,
    input  logic [IDX_W-1:0]         i_word_idx,
    input  logic [3:0]               i_byte_en,
    input  logic [31:0]              i_wdata,
    output logic [32*LINE_WORDS-1:0] o_line
);

    always_comb begin
        o_line = i_line;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (i_word_idx == IDX_W'(w)) begin
                for (int b = 0; b < 4; b++) begin
                    if (i_byte_en[b]) begin
                        o_line[32*w + 8*b +: 8] = i_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Word-to-line memory responder: read miss completes one cycle after pmem_resp; initiator holds request until mem_resp.
// Optional single-line buffer (write-through) enabled by MEM_RESPONDER_LINE_BUF_EN.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_read,
    input  logic                     mem_write,
    input  logic [31:0]              mem_address,
    input  logic [3:0]               mem_byte_enable,
    input  logic [31:0]              mem_wdata,
    output logic [31:0]              mem_rdata,
    output logic                     mem_resp,
    output logic                     pmem_read,
    output logic                     pmem_write,
    output logic [31:0]              pmem_address,
    output logic [32*LINE_WORDS-1:0] pmem_wdata,
    input  logic [32*LINE_WORDS-1:0] pmem_rdata,
    input  logic                     pmem_resp
);

    localparam int OFF_W  = line_offset_bits(LINE_WORDS);
    localparam int IDX_W  = line_index_bits(LINE_WORDS);
    localparam int LINE_W = 32 * LINE_WORDS;

    mem_responder_state_t r_state;
    logic [31:0]          r_rdata;
    logic                 r_resp;
    logic                 r_pread;
    logic                 r_pwrite;
    logic [31:0]          r_paddr;
    logic [LINE_W-1:0]    r_pwdata;

    logic [IDX_W-1:0]     w_word_idx;
    logic [31-OFF_W:0]    w_tag;
    logic [31:0]          w_line_addr;
    logic [LINE_W-1:0]    w_merge_src;
    logic [LINE_W-1:0]    w_merged;
    logic [31:0]          w_sel_word;
    logic                 w_hit;
    logic                 w_unused_addr_lsb;

    assign w_word_idx        = mem_address[OFF_W-1:2];
    assign w_tag             = mem_address[31:OFF_W];
    assign w_line_addr       = {w_tag, {OFF_W{1'b0}}};
    assign w_unused_addr_lsb = ^mem_address[1:0];

`ifdef MEM_RESPONDER_LINE_BUF_EN
    logic                 r_buf_vld;
    logic [31-OFF_W:0]    r_buf_tag;
    logic [LINE_W-1:0]    r_buf_line;

    assign w_hit       = r_buf_vld && (r_buf_tag == w_tag);
    // In IDLE the only line available is the buffered one; elsewhere it is the fetched line.
    assign w_merge_src = (r_state == ST_IDLE) ? r_buf_line : pmem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf_vld  <= 1'b0;
            r_buf_tag  <= '0;
            r_buf_line <= '0;
        end else if (r_state == ST_FETCH && pmem_resp) begin
            r_buf_vld  <= 1'b1;
            r_buf_tag  <= w_tag;
            r_buf_line <= mem_write ? w_merged : pmem_rdata;
        end else if (r_state == ST_IDLE && mem_write && w_hit && mem_byte_enable != 4'h0) begin
            r_buf_line <= w_merged;
        end
    end
`else
    assign w_hit       = 1'b0;
    assign w_merge_src = pmem_rdata;
`endif

    line_merge #(
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W)
    ) u_line_merge (
        .i_line     (w_merge_src),
        .i_word_idx (w_word_idx),
        .i_byte_en  (mem_byte_enable),
        .i_wdata    (mem_wdata),
        .o_line     (w_merged)
    );

    always_comb begin
        w_sel_word = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (w_word_idx == IDX_W'(w)) begin
                w_sel_word = w_merge_src[32*w +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_rdata  <= '0;
            r_resp   <= 1'b0;
            r_pread  <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // A write wins when both strobes are high.
                    if (mem_write) begin
                        if (mem_byte_enable == 4'h0) begin
                            r_resp  <= 1'b1;
                            r_state <= ST_RESP;
                        end else if (w_hit) begin
                            r_paddr  <= w_line_addr;
                            r_pwdata <= w_merged;
                            r_pwrite <= 1'b1;
                            r_state  <= ST_STORE;
                        end else begin
                            r_paddr <= w_line_addr;
                            r_pread <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end else if (mem_read) begin
                        if (w_hit) begin
                            r_rdata <= w_sel_word;
                            r_resp  <= 1'b1;
                            r_state <= ST_RESP;
                        end else begin
                            r_paddr <= w_line_addr;
                            r_pread <= 1'b1;
                            r_state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (pmem_resp) begin
                        r_pread <= 1'b0;
                        if (mem_write) begin
                            r_pwdata <= w_merged;
                            r_pwrite <= 1'b1;
                            r_state  <= ST_STORE;
                        end else begin
                            r_rdata <= w_sel_word;
                            r_resp  <= 1'b1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_STORE: begin
                    if (pmem_resp) begin
                        r_pwrite <= 1'b0;
                        r_resp   <= 1'b1;
                        r_state  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    r_resp  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_rdata    = r_rdata;
    assign mem_resp     = r_resp;
    assign pmem_read    = r_pread;
    assign pmem_write   = r_pwrite;
    assign pmem_address = r_paddr;
    assign pmem_wdata   = r_pwdata;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: word-addressed reference memory plus a behavioural pmem with programmable latency.
module tb_mem_responder;

    localparam int LW = 8;
    localparam int LB = 4 * LW;
`ifdef MEM_RESPONDER_LINE_BUF_EN
    localparam bit BUF_EN = 1'b1;
`else
    localparam bit BUF_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mem_read = 1'b0;
    logic            mem_write = 1'b0;
    logic [31:0]     mem_address = '0;
    logic [3:0]      mem_byte_enable = '0;
    logic [31:0]     mem_wdata = '0;
    logic [31:0]     mem_rdata;
    logic            mem_resp;
    logic            pmem_read;
    logic            pmem_write;
    logic [31:0]     pmem_address;
    logic [LW*32-1:0] pmem_wdata;
    logic [LW*32-1:0] pmem_rdata = '0;
    logic            pmem_resp = 1'b0;

    mem_responder #(.LINE_WORDS(LW)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_address    (pmem_address),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference memory (what the CPU should see) and pmem backing store, kept separately.
    logic [31:0] ref_mem [bit [31:0]];
    logic [31:0] pm_mem  [bit [31:0]];
    bit          m_buf_vld = 1'b0;
    logic [31:0] m_buf_tag = '0;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(LB - 1);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        logic [31:0] k;
        k = a & ~32'h3;
        return ref_mem.exists(k) ? ref_mem[k] : init_word(k);
    endfunction

    function automatic logic [LW*32-1:0] ref_line(input logic [31:0] la);
        logic [LW*32-1:0] l;
        for (int w = 0; w < LW; w++) l[32*w +: 32] = ref_rd(la + 32'(4*w));
        return l;
    endfunction

    function automatic logic [LW*32-1:0] pm_line(input logic [31:0] la);
        logic [LW*32-1:0] l;
        logic [31:0] k;
        for (int w = 0; w < LW; w++) begin
            k = la + 32'(4*w);
            l[32*w +: 32] = pm_mem.exists(k) ? pm_mem[k] : init_word(k);
        end
        return l;
    endfunction

    task automatic pm_store(input logic [31:0] la, input logic [LW*32-1:0] l);
        for (int w = 0; w < LW; w++) pm_mem[la + 32'(4*w)] = l[32*w +: 32];
    endtask

    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a & ~32'h3] = v;
        pm_mem[a & ~32'h3]  = v;
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] v;
        v = ref_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) v[8*b +: 8] = wd[8*b +: 8];
        ref_mem[a & ~32'h3] = v;
    endtask

    function automatic bit buf_hit(input logic [31:0] a);
        return BUF_EN && m_buf_vld && (m_buf_tag == line_of(a));
    endfunction

    // Behavioural pmem: responds after pm_lat cycles of a held request.
    int               pm_lat = 1;
    int               pm_cnt = 0;
    logic [31:0]      pm_last_waddr;
    logic [LW*32-1:0] pm_last_wdata;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && (pmem_read || pmem_write)) begin
                pm_cnt++;
                if (pm_cnt >= pm_lat) begin
                    if (pmem_read) begin
                        pmem_rdata = pm_line(pmem_address);
                    end else begin
                        pm_store(pmem_address, pmem_wdata);
                        pm_last_waddr = pmem_address;
                        pm_last_wdata = pmem_wdata;
                    end
                    pmem_resp = 1'b1;
                    @(posedge clk);
                    #1;
                    pmem_resp = 1'b0;
                    pm_cnt = 0;
                end
            end else begin
                pm_cnt = 0;
            end
        end
    end

    // Protocol watch: exclusive strobes, stable address/data, single-cycle mem_resp.
    logic             mon_act = 1'b0;
    logic             mon_presp = 1'b0;
    logic             mon_mresp = 1'b0;
    logic [31:0]      mon_addr = '0;
    logic [LW*32-1:0] mon_wdata = '0;

    always begin
        @(negedge clk);
        #3;
        if (rst) begin
            mon_act = 1'b0;
            mon_presp = 1'b0;
            mon_mresp = 1'b0;
        end else begin
            if (pmem_read || pmem_write) begin
                n_vec++;
                if ((pmem_read && pmem_write) ||
                    (mon_act && !mon_presp && (pmem_address !== mon_addr || pmem_wdata !== mon_wdata))) begin
                    n_err++;
                    $display("FAIL pmem_protocol: rd=%b wr=%b addr=%h prev_addr=%h (required exclusive strobes, stable addr/data)",
                             pmem_read, pmem_write, pmem_address, mon_addr);
                end
            end
            if (mem_resp) begin
                n_vec++;
                if (mon_mresp) begin
                    n_err++;
                    $display("FAIL mem_resp_width: got 2+ cycles high, required 1");
                end
            end
            mon_act   = pmem_read || pmem_write;
            mon_addr  = pmem_address;
            mon_wdata = pmem_wdata;
            mon_presp = pmem_resp;
            mon_mresp = mem_resp;
        end
    end

    // Transaction observations.
    bit          t_got, t_saw_r, t_saw_w;
    int          t_cycles, t_first_r, t_first_w, t_resp_cyc;
    logic [31:0] t_raddr, t_rdata;

    task automatic do_txn(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        t_got = 0; t_saw_r = 0; t_saw_w = 0;
        t_cycles = 0; t_first_r = 0; t_first_w = 0; t_resp_cyc = 0;
        t_raddr = '0; t_rdata = '0;
        pm_last_waddr = 'x;
        pm_last_wdata = 'x;
        @(posedge clk);
        #1;
        mem_read = rd; mem_write = wr; mem_address = a; mem_byte_enable = be; mem_wdata = wd;
        while (!t_got && t_cycles < 100) begin
            @(negedge clk);
            #2;
            t_cycles++;
            if (pmem_read && !t_saw_r) begin t_saw_r = 1; t_first_r = t_cycles; t_raddr = pmem_address; end
            if (pmem_write && !t_saw_w) begin t_saw_w = 1; t_first_w = t_cycles; end
            if (pmem_resp) t_resp_cyc = t_cycles;
            if (mem_resp) begin t_got = 1; t_rdata = mem_rdata; end
        end
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #2;
        n_vec++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL rst_mem_resp: got %b want 0", mem_resp); end
        n_vec++; if (pmem_read !== 1'b0) begin n_err++; $display("FAIL rst_pmem_read: got %b want 0", pmem_read); end
        n_vec++; if (pmem_write !== 1'b0) begin n_err++; $display("FAIL rst_pmem_write: got %b want 0", pmem_write); end
        n_vec++; if (mem_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mem_rdata: got %h want 0", mem_rdata); end
        n_vec++; if (pmem_address !== 32'h0) begin n_err++; $display("FAIL rst_pmem_address: got %h want 0", pmem_address); end
        n_vec++; if (pmem_wdata !== '0) begin n_err++; $display("FAIL rst_pmem_wdata: got %h want 0", pmem_wdata); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        n_vec++; if ({mem_resp, pmem_read, pmem_write} !== 3'b000) begin
            n_err++; $display("FAIL idle_after_rst: got resp/rd/wr=%b want 000", {mem_resp, pmem_read, pmem_write});
        end
    endtask

    task automatic test_read_basic();
        set_word(32'h24, 32'hDEADBEEF);
        pm_lat = 3;
        do_txn(1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        n_vec++; if (!t_got) begin n_err++; $display("FAIL rd_basic_timeout: got no mem_resp within 100 cycles, want one"); end
        n_vec++; if (t_raddr !== 32'h20) begin n_err++; $display("FAIL rd_basic_paddr: got %h want 00000020", t_raddr); end
        n_vec++; if (t_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_basic_rdata: got %h want deadbeef", t_rdata); end
        n_vec++; if (t_cycles !== t_resp_cyc + 1) begin
            n_err++; $display("FAIL rd_basic_resp_lag: mem_resp cycle %0d, pmem_resp cycle %0d, want lag 1", t_cycles, t_resp_cyc);
        end
        n_vec++; if (t_cycles !== 5) begin n_err++; $display("FAIL rd_basic_latency: got %0d want 5", t_cycles); end
        n_vec++; if (mem_resp !== 1'b0) begin n_err++; $display("FAIL rd_basic_pulse: mem_resp still %b, want 0", mem_resp); end
        m_buf_vld = 1; m_buf_tag = 32'h20;
    endtask

    task automatic test_write_sb();
        set_word(32'h40, 32'h11223344);
        pm_lat = 2;
        do_txn(1'b0, 1'b1, 32'h41, 4'h2, 32'h0000AB00);
        ref_write(32'h41, 4'h2, 32'h0000AB00);
        n_vec++; if (!t_got || t_cycles !== 6) begin n_err++; $display("FAIL sb_latency: got=%0d cycles %0d want 6", t_got, t_cycles); end
        n_vec++; if (pm_last_waddr !== 32'h40) begin n_err++; $display("FAIL sb_waddr: got %h want 00000040", pm_last_waddr); end
        n_vec++; if (pm_last_wdata[31:0] !== 32'h1122AB44) begin
            n_err++; $display("FAIL sb_word0: got %h want 1122ab44", pm_last_wdata[31:0]);
        end
        n_vec++; if (pm_last_wdata !== ref_line(32'h40)) begin
            n_err++; $display("FAIL sb_line: got %h want %h", pm_last_wdata, ref_line(32'h40));
        end
        m_buf_vld = 1; m_buf_tag = 32'h40;
    endtask

    task automatic test_write_be0();
        pm_lat = 1;
        do_txn(1'b0, 1'b1, 32'h40, 4'h0, 32'hFFFFFFFF);
        n_vec++; if (!t_got || t_cycles !== 2) begin n_err++; $display("FAIL be0_latency: got=%0d cycles %0d want 2", t_got, t_cycles); end
        n_vec++; if (t_saw_r || t_saw_w) begin n_err++; $display("FAIL be0_pmem: saw rd=%0d wr=%0d want 0/0", t_saw_r, t_saw_w); end
    endtask

    task automatic test_reset_mid_fetch();
        int resp_seen;
        pm_lat = 6;
        @(posedge clk);
        #1;
        mem_read = 1'b1; mem_address = 32'h60; mem_byte_enable = 4'hF;
        repeat (2) @(negedge clk);
        #2;
        n_vec++; if (pmem_read !== 1'b1) begin n_err++; $display("FAIL midrst_fetching: pmem_read %b want 1", pmem_read); end
        #2;
        rst = 1'b1;
        mem_read = 1'b0;
        #1;
        n_vec++; if (pmem_read !== 1'b0) begin n_err++; $display("FAIL midrst_async_drop: pmem_read %b want 0", pmem_read); end
        n_vec++; if (pmem_address !== 32'h0) begin n_err++; $display("FAIL midrst_paddr: got %h want 0", pmem_address); end
        #2;
        rst = 1'b0;
        m_buf_vld = 0;
        resp_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #2;
            if (mem_resp) resp_seen++;
        end
        n_vec++; if (resp_seen !== 0) begin n_err++; $display("FAIL midrst_no_resp: got %0d mem_resp cycles want 0", resp_seen); end
        pm_lat = 2;
        do_txn(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        n_vec++; if (!t_got || t_cycles !== 4) begin n_err++; $display("FAIL midrst_next_latency: got=%0d cycles %0d want 4", t_got, t_cycles); end
        n_vec++; if (t_raddr !== 32'h100) begin n_err++; $display("FAIL midrst_next_paddr: got %h want 00000100", t_raddr); end
        n_vec++; if (t_rdata !== ref_rd(32'h100)) begin n_err++; $display("FAIL midrst_next_rdata: got %h want %h", t_rdata, ref_rd(32'h100)); end
        m_buf_vld = 1; m_buf_tag = 32'h100;
    endtask

    task automatic test_buffer_reads();
        pm_lat = 2;
        do_txn(1'b1, 1'b0, 32'h40, 4'hF, 32'h0);
        n_vec++; if (!t_got || t_cycles !== 4 || !t_saw_r) begin
            n_err++; $display("FAIL buf_first: got=%0d cycles %0d fetched %0d want 1/4/1", t_got, t_cycles, t_saw_r);
        end
        n_vec++; if (t_rdata !== ref_rd(32'h40)) begin n_err++; $display("FAIL buf_first_rdata: got %h want %h", t_rdata, ref_rd(32'h40)); end
        m_buf_vld = 1; m_buf_tag = 32'h40;
        do_txn(1'b1, 1'b0, 32'h48, 4'hF, 32'h0);
        n_vec++; if (!t_got || t_cycles !== (BUF_EN ? 2 : 4)) begin
            n_err++; $display("FAIL buf_second_latency: got=%0d cycles %0d want %0d", t_got, t_cycles, BUF_EN ? 2 : 4);
        end
        n_vec++; if (t_saw_r !== !BUF_EN) begin n_err++; $display("FAIL buf_second_fetch: fetched %0d want %0d", t_saw_r, !BUF_EN); end
        n_vec++; if (t_rdata !== ref_rd(32'h48)) begin n_err++; $display("FAIL buf_second_rdata: got %h want %h", t_rdata, ref_rd(32'h48)); end
    endtask

    task automatic test_read_write_both();
        logic [31:0] wd;
        wd = $urandom;
        pm_lat = 1;
        do_txn(1'b1, 1'b1, 32'h80, 4'hF, wd);
        ref_write(32'h80, 4'hF, wd);
        n_vec++; if (!t_got || t_cycles !== 4) begin n_err++; $display("FAIL rw_latency: got=%0d cycles %0d want 4", t_got, t_cycles); end
        n_vec++; if (!(t_saw_r && t_saw_w && t_first_r < t_first_w)) begin
            n_err++; $display("FAIL rw_order: read@%0d write@%0d want fetch before store", t_first_r, t_first_w);
        end
        n_vec++; if (pm_last_wdata !== ref_line(32'h80)) begin
            n_err++; $display("FAIL rw_line: got %h want %h", pm_last_wdata, ref_line(32'h80));
        end
        m_buf_vld = 1; m_buf_tag = 32'h80;
    endtask

    task automatic test_random();
        int          sel, lat, exp_cyc;
        bit          rd, wr, hit, exp_r, exp_w;
        logic [31:0] a, wd;
        logic [3:0]  be;
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(1, 3);
            rd  = sel[0];
            wr  = sel[1];
            a   = 32'($urandom_range(0, 32'h17F));
            be  = 4'($urandom_range(0, 15));
            wd  = $urandom;
            lat = $urandom_range(1, 3);
            pm_lat = lat;
            hit = buf_hit(a);
            if (wr && be == 4'h0) begin
                exp_r = 0; exp_w = 0; exp_cyc = 2;
            end else if (wr) begin
                exp_r = !hit; exp_w = 1; exp_cyc = hit ? lat + 2 : 2*lat + 2;
            end else begin
                exp_r = !hit; exp_w = 0; exp_cyc = hit ? 2 : lat + 2;
            end
            do_txn(rd, wr, a, be, wd);
            n_vec++; if (!t_got || t_cycles !== exp_cyc) begin
                n_err++; $display("FAIL rnd_latency[%0d]: rd=%0d wr=%0d a=%h got=%0d cycles %0d want %0d", n, rd, wr, a, t_got, t_cycles, exp_cyc);
            end
            n_vec++; if (t_saw_r !== exp_r || t_saw_w !== exp_w) begin
                n_err++; $display("FAIL rnd_pmem[%0d]: rd/wr seen %0d/%0d want %0d/%0d", n, t_saw_r, t_saw_w, exp_r, exp_w);
            end
            if (wr && be != 4'h0) begin
                ref_write(a, be, wd);
                n_vec++; if (pm_last_waddr !== line_of(a) || pm_last_wdata !== ref_line(line_of(a))) begin
                    n_err++; $display("FAIL rnd_wline[%0d]: addr %h data %h want %h %h", n, pm_last_waddr, pm_last_wdata, line_of(a), ref_line(line_of(a)));
                end
            end else if (!wr) begin
                n_vec++; if (t_rdata !== ref_rd(a)) begin
                    n_err++; $display("FAIL rnd_rdata[%0d]: a=%h got %h want %h", n, a, t_rdata, ref_rd(a));
                end
                n_vec++; if (t_raddr !== (exp_r ? line_of(a) : 32'h0)) begin
                    n_err++; $display("FAIL rnd_paddr[%0d]: got %h want %h", n, t_raddr, exp_r ? line_of(a) : 32'h0);
                end
            end
            if (exp_r) begin
                m_buf_vld = 1;
                m_buf_tag = line_of(a);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_sb();
        test_write_be0();
        test_reset_mid_fetch();
        test_buffer_reads();
        test_read_write_both();
        test_random();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
